// File: rtl/lcd_ci_pkg.sv
// Shared definitions for the LCD custom-instruction writer: FSM state set,
// dataA field positions and elaboration-time helpers.
package lcd_ci_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } lcd_state_e;

    // dataA control bits
    localparam int RS_BIT   = 0;
    localparam int LONG_BIT = 1;

    // Only 8-bit and 4-bit (nibble) LCD buses exist on HD44780 parts.
    function automatic bit bus_w_legal(input int w);
        return (w == 8) || (w == 4);
    endfunction

    // Largest of the phase lengths; sizes the shared phase counter.
    function automatic int max_cyc(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/lcd_ci_writer_if.sv
// Custom-instruction handshake plus LCD pin bundle. The processor side is
// the master; the writer is the slave that also drives the LCD pins.
interface lcd_ci_writer_if #(
    parameter int BUS_W = 8
);
    logic             clk_en;
    logic             start;
    logic [31:0]      dataA;
    logic [31:0]      dataB;
    logic [31:0]      result;
    logic             done;
    logic             read_write;
    logic             register_select;
    logic             enable_op;
    logic [BUS_W-1:0] data_out;

    modport master (
        output clk_en, start, dataA, dataB,
        input  result, done, read_write, register_select, enable_op, data_out
    );

    modport slave (
        input  clk_en, start, dataA, dataB,
        output result, done, read_write, register_select, enable_op, data_out
    );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one bus phase. 'expired' is high during
// the last enabled cycle of a phase, so a phase loaded with N lasts exactly
// N enabled cycles.
module lcd_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);
    logic [CNT_W-1:0] count_reg;

    // Load takes priority; otherwise count down while enabled, parking at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign expired = (count_reg <= CNT_W'(1));

endmodule

// File: rtl/lcd_ci_writer.sv
// Nios II multicycle custom instruction that writes one command/data byte
// to an HD44780-class LCD, sequencing RS/data setup, the E pulse, hold and
// the post-write execution delay before pulsing done.
module lcd_ci_writer
    import lcd_ci_pkg::*;
#(
    parameter int BUS_W     = 8,
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 25,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2500,
    parameter int LONG_CYC  = 100000
) (
    input  logic           clk,
    input  logic           reset,
    lcd_ci_writer_if.slave bus
);
    localparam int CNT_W = $clog2(max_cyc(SETUP_CYC, PULSE_CYC, HOLD_CYC,
                                          EXEC_CYC, LONG_CYC)) + 1;

    localparam logic [2:0] ST_IDLE  = 3'(S_IDLE);
    localparam logic [2:0] ST_SETUP = 3'(S_SETUP);
    localparam logic [2:0] ST_PULSE = 3'(S_PULSE);
    localparam logic [2:0] ST_HOLD  = 3'(S_HOLD);
    localparam logic [2:0] ST_WAIT  = 3'(S_WAIT);
    localparam logic [2:0] ST_DONE  = 3'(S_DONE);

    if (!bus_w_legal(BUS_W)) begin : g_bad_bus_w
        $error("lcd_ci_writer: BUS_W must be 8 or 4");
    end

    logic [2:0]       state_reg, state_next;
    logic             rs_reg;
    logic             long_reg;
    logic [3:0]       low_nib_reg;
    logic             nibble_reg;
    logic             e_reg;
    logic [BUS_W-1:0] data_reg;
    logic             done_reg;
    logic [31:0]      result_reg;

    logic             accept;
    logic             step;
    logic             second_beat;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_expired;
    logic             unused_bits;

    // Only RS, LONG and the low byte of the operands carry meaning.
    assign unused_bits = ^{bus.dataA[31:2], bus.dataB[31:8]};

    // A phase ends on its last enabled cycle; nothing advances while frozen.
    assign step        = bus.clk_en && timer_expired;
    // In nibble mode the low nibble still has to go out after the first pulse.
    assign second_beat = (BUS_W == 4) && !nibble_reg;

    lcd_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.clk_en),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // Next-state decode; each phase entry reloads the timer with its length.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_reg)
            ST_IDLE: begin
                // done_reg blocks a start that overlaps the completion pulse.
                if (bus.clk_en && bus.start && !done_reg) begin
                    accept     = 1'b1;
                    state_next = ST_SETUP;
                    timer_load = 1'b1;
                    timer_val  = CNT_W'(SETUP_CYC);
                end
            end
            ST_SETUP: begin
                if (step) begin
                    state_next = ST_PULSE;
                    timer_load = 1'b1;
                    timer_val  = CNT_W'(PULSE_CYC);
                end
            end
            ST_PULSE: begin
                if (step) begin
                    state_next = ST_HOLD;
                    timer_load = 1'b1;
                    timer_val  = CNT_W'(HOLD_CYC);
                end
            end
            ST_HOLD: begin
                if (step) begin
                    timer_load = 1'b1;
                    if (second_beat) begin
                        state_next = ST_SETUP;
                        timer_val  = CNT_W'(SETUP_CYC);
                    end else begin
                        state_next = ST_WAIT;
                        timer_val  = long_reg ? CNT_W'(LONG_CYC) : CNT_W'(EXEC_CYC);
                    end
                end
            end
            ST_WAIT: begin
                if (step) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.clk_en) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture, LCD pin drive and completion reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_reg      <= 1'b0;
            long_reg    <= 1'b0;
            low_nib_reg <= 4'h0;
            nibble_reg  <= 1'b0;
            e_reg       <= 1'b0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            result_reg  <= 32'd0;
        end else begin
            // done is a single-cycle pulse even if clk_en drops right after.
            done_reg <= 1'b0;
            if (accept) begin
                rs_reg      <= bus.dataA[RS_BIT];
                long_reg    <= bus.dataA[LONG_BIT];
                low_nib_reg <= bus.dataB[3:0];
                nibble_reg  <= 1'b0;
                data_reg    <= (BUS_W == 8) ? BUS_W'(bus.dataB[7:0])
                                            : BUS_W'(bus.dataB[7:4]);
            end
            if ((state_reg == ST_SETUP) && (state_next == ST_PULSE)) begin
                e_reg <= 1'b1;
            end
            if ((state_reg == ST_PULSE) && (state_next == ST_HOLD)) begin
                e_reg <= 1'b0;
            end
            if ((state_reg == ST_HOLD) && (state_next == ST_SETUP)) begin
                data_reg   <= BUS_W'(low_nib_reg);
                nibble_reg <= 1'b1;
            end
            if ((state_reg == ST_DONE) && (state_next == ST_IDLE)) begin
                done_reg   <= 1'b1;
                result_reg <= result_reg + 32'd1;
            end
        end
    end

    assign bus.read_write      = 1'b0;
    assign bus.register_select = rs_reg;
    assign bus.enable_op       = e_reg;
    assign bus.data_out        = data_reg;
    assign bus.done            = done_reg;
    assign bus.result          = result_reg;

endmodule

// File: tb/tb_lcd_ci_writer.sv
// Self-checking bench for lcd_ci_writer: one 8-bit and one 4-bit instance,
// directed scenarios plus random writes with random clk_en freezes.
module tb_lcd_ci_writer;
    localparam int SETUP_C = 2;
    localparam int PULSE_C = 4;
    localparam int HOLD_C  = 2;
    localparam int EXEC_C  = 10;
    localparam int LONG_C  = 50;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_ci_writer_if #(.BUS_W(8)) bus8();
    lcd_ci_writer_if #(.BUS_W(4)) bus4();

    lcd_ci_writer #(
        .BUS_W(8), .SETUP_CYC(SETUP_C), .PULSE_CYC(PULSE_C), .HOLD_CYC(HOLD_C),
        .EXEC_CYC(EXEC_C), .LONG_CYC(LONG_C)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    lcd_ci_writer #(
        .BUS_W(4), .SETUP_CYC(SETUP_C), .PULSE_CYC(PULSE_C), .HOLD_CYC(HOLD_C),
        .EXEC_CYC(EXEC_C), .LONG_CYC(LONG_C)
    ) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_count[2];
    int   done_cnt[2] = '{0, 0};
    int   tot;
    int   base;
    logic sel;

    logic        obs_e, obs_rs, obs_done, obs_rw;
    logic [7:0]  obs_data;
    logic [31:0] obs_result;

    // Observe whichever instance the current transaction targets.
    always_comb begin
        obs_e      = bus8.enable_op;
        obs_rs     = bus8.register_select;
        obs_done   = bus8.done;
        obs_rw     = bus8.read_write;
        obs_data   = bus8.data_out;
        obs_result = bus8.result;
        if (sel) begin
            obs_e      = bus4.enable_op;
            obs_rs     = bus4.register_select;
            obs_done   = bus4.done;
            obs_rw     = bus4.read_write;
            obs_data   = {4'h0, bus4.data_out};
            obs_result = bus4.result;
        end
    end

    // Count done pulses per instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus8.done === 1'b1) done_cnt[0]++;
        if (bus4.done === 1'b1) done_cnt[1]++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic st, input logic en,
                         input logic [31:0] a, input logic [31:0] b);
        if (s) begin
            bus4.start = st; bus4.clk_en = en; bus4.dataA = a; bus4.dataB = b;
        end else begin
            bus8.start = st; bus8.clk_en = en; bus8.dataA = a; bus8.dataB = b;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_e"},      32'(obs_e), 0);
        check_val({tag, "_rs"},     32'(obs_rs), 0);
        check_val({tag, "_data"},   32'(obs_data), 0);
        check_val({tag, "_done"},   32'(obs_done), 0);
        check_val({tag, "_result"}, obs_result, 0);
        check_val({tag, "_rw"},     32'(obs_rw), 0);
    endtask

    // One instruction: expected timing is counted in enabled clock edges
    // from the accepting edge, bus contents come from the byte and mode.
    task automatic run_write(input logic s, input logic [31:0] a, input logic [31:0] b,
                             input int gap_pct, input int fixed_gap,
                             input bit extra_start, input bit start_on_done,
                             output int total_edges);
        int         beats, lat, en_edges, hi_cnt, pulses, gap_left, budget, e_seen;
        bit         en, prev_e, seen_done, xs;
        logic [7:0] beat_data[2];
        string      tg;
        beats = s ? 2 : 1;
        lat   = 1 + beats * (SETUP_C + PULSE_C + HOLD_C) + (a[1] ? LONG_C : EXEC_C);
        if (s) begin
            beat_data[0] = {4'h0, b[7:4]};
            beat_data[1] = {4'h0, b[3:0]};
        end else begin
            beat_data[0] = b[7:0];
            beat_data[1] = b[7:0];
        end
        tg  = s ? "w4" : "w8";
        sel = s;
        drive(s, 1'b1, 1'b1, a, b);
        @(posedge clk); #1;
        en_edges = 0; hi_cnt = 0; pulses = 0; total_edges = 0;
        prev_e = obs_e; seen_done = 0; gap_left = fixed_gap;
        budget = lat + 400;
        while (!seen_done && total_edges < budget) begin
            en = 1'b1;
            if (fixed_gap > 0 && obs_e && gap_left > 0) begin
                en = 1'b0;
                gap_left--;
            end else if (gap_pct > 0 && !extra_start && $urandom_range(99) < gap_pct) begin
                en = 1'b0;
            end
            xs = extra_start && (total_edges == 0);
            drive(s, xs, en, xs ? ~a : a, xs ? ~b : b);
            @(posedge clk); #1;
            total_edges++;
            if (en) en_edges++;
            if (!prev_e && obs_e) begin
                check_val({tg, "_data_at_e_rise"}, 32'(obs_data), 32'(beat_data[(pulses > 1) ? 1 : pulses]));
                check_val({tg, "_rs_at_e_rise"}, 32'(obs_rs), 32'(a[0]));
                hi_cnt = 0;
            end
            if (prev_e && en) hi_cnt++;
            if (prev_e && !obs_e) begin
                pulses++;
                check_val({tg, "_e_high_cycles"}, hi_cnt, PULSE_C);
            end
            if (obs_done) begin
                seen_done = 1;
                exp_count[s] = exp_count[s] + 1;
                check_val({tg, "_done_latency"}, en_edges, lat);
                check_val({tg, "_result"}, obs_result, exp_count[s]);
                check_val({tg, "_pulses"}, pulses, beats);
                check_val({tg, "_data_held"}, 32'(obs_data), 32'(beat_data[beats-1]));
            end
            prev_e = obs_e;
        end
        check_val({tg, "_done_seen"}, 32'(seen_done), 1);
        // Cycle after done: clk_en low (done must still clear) or a start
        // overlapping done (must be ignored).
        drive(s, start_on_done, start_on_done, a, b ^ 32'h5A);
        @(posedge clk); #1;
        check_val({tg, "_done_one_cycle"}, 32'(obs_done), 0);
        drive(s, 1'b0, 1'b1, a, b);
        if (start_on_done) begin
            e_seen = 0;
            repeat (SETUP_C + 4) begin
                @(posedge clk); #1;
                if (obs_e || obs_done) e_seen++;
            end
            check_val({tg, "_start_on_done_ignored"}, e_seen, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        sel       = 1'b0;
        exp_count = '{0, 0};
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0; #1; check_reset_outputs("rst8");
        sel = 1'b1; #1; check_reset_outputs("rst4");
        reset = 1'b0;
        @(posedge clk); #1;

        // 8-bit data write, 8-bit long command, 4-bit data write
        run_write(1'b0, 32'h1, 32'h41, 0, 0, 0, 0, tot);
        run_write(1'b0, 32'h2, 32'h01, 0, 0, 0, 0, tot);
        run_write(1'b1, 32'h1, 32'hA5, 0, 0, 0, 0, tot);

        // clk_en low for 7 cycles inside the E pulse
        run_write(1'b0, 32'h1, 32'h3C, 0, 7, 0, 0, tot);
        check_val("freeze_total_latency", tot, 26);

        // reset during WAIT
        sel = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h1, 32'h55);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h1, 32'h55);
        repeat (SETUP_C + PULSE_C + HOLD_C + 3) @(posedge clk);
        #2;
        check_val("pre_rst_result", obs_result, exp_count[0]);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("wait_rst");
        base = done_cnt[0];
        @(posedge clk); #1;
        reset = 1'b0;
        exp_count = '{0, 0};
        repeat (LONG_C) @(posedge clk);
        #1;
        check_val("wait_rst_no_done", done_cnt[0] - base, 0);

        // reset while E is high: E must drop without a clock edge
        drive(1'b0, 1'b1, 1'b1, 32'h1, 32'h66);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h1, 32'h66);
        repeat (SETUP_C) @(posedge clk);
        #2;
        check_val("pre_rst_e_high", 32'(obs_e), 1);
        #1 reset = 1'b1;
        #1;
        check_val("pulse_rst_e_async", 32'(obs_e), 0);
        check_val("pulse_rst_rs", 32'(obs_rs), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        base = done_cnt[0];
        repeat (30) @(posedge clk);
        #1;
        check_val("pulse_rst_no_done", done_cnt[0] - base, 0);

        // extra start during SETUP, then back-to-back writes
        base = done_cnt[0];
        run_write(1'b0, 32'h1, 32'h31, 0, 0, 1, 0, tot);
        run_write(1'b0, 32'h0, 32'h32, 0, 0, 0, 1, tot);
        run_write(1'b0, 32'h3, 32'h33, 0, 0, 0, 0, tot);
        check_val("b2b_done_pulses", done_cnt[0] - base, 3);
        check_val("b2b_result", obs_result, 3);

        // random writes with random clk_en freezes on both bus widths
        for (int i = 0; i < 10; i++) begin
            run_write(1'($urandom_range(1)), $urandom, $urandom,
                      int'($urandom_range(25)), 0, 0, 0, tot);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_ci_writer.md
# lcd_ci_writer

Parametrised Nios II multicycle custom-instruction slave that writes one command or data byte to an HD44780-class character LCD per instruction. It generates the RS/E/data bus timing from parameterised cycle counts and supports 8-bit and 4-bit (two-nibble) bus modes. It provides a short or long post-write execution delay, selected per instruction. `done` signals the processor only after the LCD has had time to execute the write.

## Interface
Parameters:
- `BUS_W`, 8: LCD data bus width; legal values are 8 or 4 (4 = nibble mode on `lcd_data[3:0]`).
- `SETUP_CYC`, 4: cycles RS/data are stable before E rises (≥1).
- `PULSE_CYC`, 25: cycles E is high (≥1).
- `HOLD_CYC`, 4: cycles RS/data are held after E falls (≥1).
- `EXEC_CYC`, 2500: post-write wait for normal commands and data (≥1).
- `LONG_CYC`, 100000: post-write wait for clear/home (≥1).

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `clk_en`, in, 1: custom-instruction clock enable; when low, the FSM and counters freeze.
- `start`, in, 1: custom-instruction start.
- `dataA`, in, 32: bit0 = RS (0 command, 1 data); bit1 = LONG wait select; bits 31:2 are ignored.
- `dataB`, in, 32: bits 7:0 hold the byte to write; bits 31:8 are ignored.
- `result`, out, 32: count of completed writes since reset.
- `done`, out, 1: one-cycle completion pulse.
- `read_write`, out, 1: LCD R/W, constant 0.
- `register_select`, out, 1: LCD RS.
- `enable_op`, out, 1: LCD E; active high, and the LCD latches on the falling edge.
- `data_out`, out, BUS_W: LCD data bus.

## Operation
- Reset values: `result` = 0, `done` = 0, `register_select` = 0, `enable_op` = 0, `data_out` = 0, state = IDLE, counter = 0.
- States: IDLE, SETUP, PULSE, HOLD, WAIT, DONE.
- IDLE:
  - On `start` & `clk_en`, latch RS, LONG and the byte.
  - Drive `register_select` and `data_out` (8-bit mode: the full byte; 4-bit mode: the high nibble).
  - Clear the nibble flag, load the counter with SETUP_CYC, and go to SETUP.
  - `start` is ignored in every other state.
- SETUP → PULSE after SETUP_CYC cycles. `enable_op` goes to 1 on entry to PULSE.
- PULSE → HOLD after PULSE_CYC cycles. `enable_op` goes to 0 on entry to HOLD.
- HOLD, after HOLD_CYC cycles:
  - 4-bit mode, first nibble: drive the low nibble, set the nibble flag, and return to SETUP.
  - Otherwise go to WAIT, loading the counter with LONG_CYC if LONG is set, else EXEC_CYC.
- WAIT → DONE when the counter expires.
- DONE: `done` = 1 for exactly one cycle, `result` increments by 1 (wraps at 2^32), then return to IDLE. `done` clears on the next clock edge regardless of `clk_en`.
- `register_select` and `data_out` hold their values from capture until the next capture.
- Phase counter:
  - Each phase of N cycles lasts exactly N enabled clock cycles.
  - Counter width is `$clog2` of the largest parameter + 1.
  - Counting stops while `clk_en` = 0; E and the bus keep their levels during the freeze.
- Reset asserted mid-transfer: all outputs return to their reset values immediately, with E dropping asynchronously. No partial `done` is produced.

## Timing
- All latencies below assume `clk_en` stays high. A `start` sampled at edge t gives `done` high during the cycle after edge t+L:
  - 8-bit mode: L = 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC + W.
  - 4-bit mode: L = 1 + 2·(SETUP_CYC + PULSE_CYC + HOLD_CYC) + W.
  - W = LONG_CYC if dataA[1] = 1, else EXEC_CYC.
- `start` held high on the same cycle `done` is asserted is not accepted. A back-to-back instruction is accepted from IDLE, one cycle later at the earliest.
- `result` updates on the same edge `done` rises and is valid while `done` = 1.

## Structure
- Shared package `lcd_ci_pkg` holds:
  - the state enum;
  - dataA field positions (RS_BIT = 0, LONG_BIT = 1);
  - the `BUS_W` legality check as an elaboration-time assertion.
- Sub-module `lcd_phase_timer`: a loadable down-counter with enable and an `expired` flag. The FSM reloads it on each phase entry.

## Test plan
Parameters for the bench: SETUP_CYC = 2, PULSE_CYC = 4, HOLD_CYC = 2, EXEC_CYC = 10, LONG_CYC = 50.
1. BUS_W = 8, dataA = 1, dataB = 0x41 → RS = 1, `data_out` = 0x41, E high exactly 4 cycles, `done` at L = 19, `result` = 1.
2. BUS_W = 8, dataA = 2 (command, LONG), dataB = 0x01 → RS = 0, `done` at L = 59.
3. BUS_W = 4, dataA = 1, dataB = 0xA5 → two E pulses of 4 cycles, first with `data_out` = 0xA, then 0x5; `done` at L = 27.
4. `clk_en` low for 7 cycles during PULSE → E stays high and `done` arrives 7 cycles later (L = 26 in 8-bit mode).
5. `reset` pulsed during WAIT → all outputs 0 without waiting for a clock edge, no `done`; a following write completes normally with `result` = 1.
6. `start` pulsed again during SETUP, then three back-to-back writes → the extra start is ignored; `result` ends at 3, with exactly three `done` pulses.
